// File: rtl/iiitb_tlc_pkg.sv
// +----------------------------------------------------------------------+
// | iiitb_tlc_pkg : shared light codes, sensor FSM states and defaults   |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

package iiitb_tlc_pkg;

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;

  localparam int DEF_DEB_CYCLES = 4;
  localparam int DEF_MAX_WAIT   = 1000;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_REQ    = 4'b0010,
    ST_SERVED = 4'b0100,
    ST_CLEAR  = 4'b1000
  } sensor_state_t;

endpackage

`default_nettype wire

// File: rtl/iiitb_tlc_debounce.sv
// +----------------------------------------------------------------------+
// | iiitb_tlc_debounce : 2-flop synchroniser plus level debouncer        |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module iiitb_tlc_debounce
  import iiitb_tlc_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic loop_raw,
  output logic present
);

  localparam int c_cnt_w = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(DEB_CYCLES - 1);

  logic               r_sync1;
  logic               r_sync2;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_present;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_cnt     <= '0;
      r_present <= 1'b0;
    end else begin
      r_sync1 <= loop_raw;
      r_sync2 <= r_sync1;
      // Any sample agreeing with the current level restarts the run.
      if (r_sync2 != r_present) begin
        if (r_cnt == c_last) begin
          r_present <= ~r_present;
          r_cnt     <= '0;
        end else begin
          r_cnt <= r_cnt + c_cnt_w'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign present = r_present;

endmodule

`default_nettype wire

// File: rtl/iiitb_tlc_sensor_if.sv
// +----------------------------------------------------------------------+
// | iiitb_tlc_sensor_if : farm-road detector front end and request latch |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module iiitb_tlc_sensor_if
  import iiitb_tlc_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int MAX_WAIT   = DEF_MAX_WAIT,
  parameter int WAIT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              loop_raw,
  input  logic [2:0]        light_farm,
  output logic              sensor,
  output logic              present,
  output logic              starved,
  output logic [WAIT_W-1:0] wait_cycles,
  output logic [7:0]        serve_count
);

  localparam logic [WAIT_W-1:0] c_max_wait = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] c_wait_sat = '1;

  sensor_state_t     r_state;
  sensor_state_t     w_next;
  logic              w_sensor_d;
  logic              w_light_ok;
  logic              w_serve;
  logic              w_present;
  logic              r_sensor;
  logic              r_starved;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] r_wait_cycles;
  logic [7:0]        r_serve_count;

  iiitb_tlc_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .rst      (rst),
    .loop_raw (loop_raw),
    .present  (w_present)
  );

  always_comb begin
    w_next     = r_state;
    w_sensor_d = 1'b0;
    w_light_ok = (light_farm == LIGHT_RED) || (light_farm == LIGHT_YELLOW) ||
                 (light_farm == LIGHT_GREEN);
    case (r_state)
      ST_IDLE:   if (w_present) w_next = ST_REQ;
      ST_REQ:    if (light_farm == LIGHT_GREEN) w_next = ST_SERVED;
      ST_SERVED: if (light_farm == LIGHT_RED) w_next = ST_CLEAR;
      ST_CLEAR:  w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
    // An undefined light code freezes the FSM wherever it is.
    if (!w_light_ok) w_next = r_state;
    w_serve = (r_state == ST_REQ) && (w_next == ST_SERVED);
    case (w_next)
      ST_REQ:    w_sensor_d = 1'b1;
      ST_SERVED: w_sensor_d = w_present;
      default:   w_sensor_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_sensor <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_sensor <= w_sensor_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt    <= '0;
      r_wait_cycles <= '0;
      r_serve_count <= 8'd0;
      r_starved     <= 1'b0;
    end else if (r_state == ST_REQ) begin
      if (r_wait_cnt == c_max_wait) r_starved <= 1'b1;
      if (w_serve) begin
        r_wait_cycles <= r_wait_cnt;
        r_serve_count <= r_serve_count + 8'd1;
        r_wait_cnt    <= '0;
      end else if (r_wait_cnt != c_wait_sat) begin
        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
      end
    end
  end

  assign sensor      = r_sensor;
  assign present     = w_present;
  assign starved     = r_starved;
  assign wait_cycles = r_wait_cycles;
  assign serve_count = r_serve_count;

endmodule

`default_nettype wire

// File: tb/tb_iiitb_tlc_sensor_if.sv
// +----------------------------------------------------------------------+
// | tb_iiitb_tlc_sensor_if : directed bench for the farm sensor front end|
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_iiitb_tlc_sensor_if;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;

  logic        clk;
  logic        rst;
  logic        loop_raw;
  logic [2:0]  light_farm;
  logic        sensor;
  logic        present;
  logic        starved;
  logic [15:0] wait_cycles;
  logic [7:0]  serve_count;

  int checks = 0;
  int errors = 0;

  iiitb_tlc_sensor_if #(
    .DEB_CYCLES (4),
    .MAX_WAIT   (20),
    .WAIT_W     (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .loop_raw    (loop_raw),
    .light_farm  (light_farm),
    .sensor      (sensor),
    .present     (present),
    .starved     (starved),
    .wait_cycles (wait_cycles),
    .serve_count (serve_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    loop_raw = 1'b0;
    light_farm = RED;
    step(2);
    rst = 1'b0;
  endtask

  // Served -> RED -> CLEAR -> IDLE -> REQ -> GREEN served again (present held high)
  task automatic serve_once();
    light_farm = RED;
    step(1);
    light_farm = GREEN;
    step(3);
  endtask

  initial begin
    rst = 1'b1;
    loop_raw = 1'b1;
    light_farm = RED;

    // Reset held with detector active
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("rst_sensor", sensor, 0);
      chk("rst_present", present, 0);
      chk("rst_serve", serve_count, 0);
      chk("rst_starved", starved, 0);
    end
    rst = 1'b0;

    // Full cycle, edges counted from reset release
    step(5);
    chk("fc_present_e5", present, 0);
    step(1);
    chk("fc_present_e6", present, 1);
    chk("fc_sensor_e6", sensor, 0);
    step(1);
    chk("fc_sensor_e7", sensor, 1);
    step(20);
    chk("fc_starved_e27", starved, 0);
    chk("fc_sensor_e27", sensor, 1);
    step(1);
    chk("fc_starved_e28", starved, 1);
    step(28);
    light_farm = GREEN;
    loop_raw = 1'b0;
    step(1);
    chk("fc_wait", wait_cycles, 49);
    chk("fc_serve", serve_count, 1);
    chk("fc_sensor_green", sensor, 1);
    step(5);
    chk("fc_present_fall", present, 0);
    chk("fc_sensor_lag", sensor, 1);
    step(1);
    chk("fc_sensor_follow", sensor, 0);
    light_farm = YELLOW;
    step(2);
    chk("fc_sensor_yellow", sensor, 0);
    light_farm = RED;
    step(2);
    chk("fc_sensor_idle", sensor, 0);
    chk("fc_serve_end", serve_count, 1);
    chk("fc_wait_end", wait_cycles, 49);
    chk("fc_starved_end", starved, 1);

    // Reset clears statistics
    do_reset();
    chk("rr_wait", wait_cycles, 0);
    chk("rr_serve", serve_count, 0);
    chk("rr_starved", starved, 0);

    // Three-cycle glitch is rejected
    loop_raw = 1'b1;
    step(3);
    loop_raw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk("gl_present", present, 0);
      chk("gl_sensor", sensor, 0);
    end

    // Latched request outlives the vehicle
    loop_raw = 1'b1;
    step(6);
    chk("la_present", present, 1);
    step(1);
    chk("la_sensor_e7", sensor, 1);
    step(3);
    loop_raw = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      chk("la_sensor_hold", sensor, 1);
    end
    chk("la_present_gone", present, 0);
    light_farm = GREEN;
    step(1);
    chk("la_wait", wait_cycles, 103);
    chk("la_serve", serve_count, 1);
    chk("la_sensor_served", sensor, 0);
    light_farm = RED;
    step(2);
    chk("la_sensor_idle", sensor, 0);
    chk("la_starved_sticky", starved, 1);

    // GREEN coinciding with request in IDLE, then wrap
    do_reset();
    light_farm = GREEN;
    loop_raw = 1'b1;
    step(6);
    chk("sg_present", present, 1);
    chk("sg_sensor_e6", sensor, 0);
    step(1);
    chk("sg_sensor_e7", sensor, 1);
    chk("sg_serve_e7", serve_count, 0);
    step(1);
    chk("sg_serve_e8", serve_count, 1);
    chk("sg_wait_e8", wait_cycles, 0);

    light_farm = RED;
    step(1);
    chk("cl_sensor_clear", sensor, 0);
    light_farm = GREEN;
    step(1);
    chk("cl_sensor_idle", sensor, 0);
    step(1);
    chk("cl_sensor_req", sensor, 1);
    chk("cl_serve_req", serve_count, 1);
    step(1);
    chk("cl_serve", serve_count, 2);
    chk("cl_sensor_served", sensor, 1);

    // Undefined light codes freeze the FSM in SERVED
    light_farm = 3'b111;
    step(3);
    chk("il_sensor_111", sensor, 1);
    chk("il_serve_111", serve_count, 2);
    light_farm = 3'b000;
    step(1);
    chk("il_sensor_000", sensor, 1);

    for (int i = 0; i < 253; i++) serve_once();
    chk("wr_serve_255", serve_count, 255);
    serve_once();
    chk("wr_serve_0", serve_count, 0);
    chk("wr_sensor", sensor, 1);
    chk("wr_starved", starved, 0);

    // Reset while SERVED with sensor high
    rst = 1'b1;
    step(1);
    chk("rm_sensor", sensor, 0);
    chk("rm_present", present, 0);
    chk("rm_serve", serve_count, 0);
    chk("rm_wait", wait_cycles, 0);
    chk("rm_starved", starved, 0);
    rst = 1'b0;
    step(5);
    chk("rm_sensor_e5", sensor, 0);
    step(1);
    chk("rm_present_e6", present, 1);
    chk("rm_sensor_e6", sensor, 0);
    step(1);
    chk("rm_sensor_e7", sensor, 1);
    chk("rm_serve_e7", serve_count, 0);
    step(1);
    chk("rm_serve_e8", serve_count, 1);
    chk("rm_wait_e8", wait_cycles, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
